// File: rtl/multicycle_cpu_core.sv
// multicycle_cpu_core
//   Multi-cycle CPU: FETCH -> DECODE -> EXECUTE -> WRITEBACK, one instruction
//   every four cycles while `step` stays high. Instruction memory is a
//   registered synchronous port (data valid the cycle after imem_rd_en).
//   r0 is hardwired to zero, and register indices >= NREGS read as zero and
//   ignore writes. A HALT instruction parks the core until reset.
//
// Parameters
//   DATA_W  datapath / register width (>= 8)
//   PC_W    PC and instruction-address width (<= 16, branch targets come
//           from the 16-bit immediate)
//   NREGS   implemented registers, 2..32
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   step            run enable, sampled in IDLE and at WRITEBACK
//   imem_rd_en      instruction read strobe (high in FETCH)
//   imem_addr       instruction address (= pc)
//   imem_data       instruction word, one cycle after imem_rd_en
//   pc              current program counter
//   result          last ALU write-back value
//   result_valid    high during WRITEBACK of an ALU-class instruction
//   halted          high in HALTED
//   state           IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 WRITEBACK=4 HALTED=5
//
// Build option
//   CPU_BNE_EN      when defined, opcode 000101 is BNE; otherwise a NOP.

module multicycle_cpu_core #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    output logic              imem_rd_en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_data,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              halted,
    output logic [2:0]        state
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [5:0] OP_ADD  = 6'b010000;
    localparam logic [5:0] OP_SUB  = 6'b011000;
    localparam logic [5:0] OP_SHL  = 6'b100000;
    localparam logic [5:0] OP_SHR  = 6'b101000;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_SUBI = 6'b111000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;
`ifdef CPU_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5
    } state_t;

    // Instruction register. The rs field is consumed at DECODE (operand A)
    // and is not needed afterwards, so it is not kept. `lo` carries rd,
    // the immediate and the jump target.
    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [15:0] lo;
    } ir_t;

    state_t st, st_nxt;
    ir_t    ir;

    logic [NREGS-1:1][DATA_W-1:0] regs;   // r0 has no storage
    logic [DATA_W-1:0] a, b, aluout, alu_y, imm_ext, rf_a, rf_b;
    logic              br_take, br_take_nxt, is_alu, is_rtype;
    logic [4:0]        wr_idx;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= S_IDLE;
        else       st <= st_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        st_nxt = st;
        case (st)
            S_IDLE:      st_nxt = step ? S_FETCH : S_IDLE;
            S_FETCH:     st_nxt = S_DECODE;
            S_DECODE:    st_nxt = (imem_data[31:26] == OP_HALT) ? S_HALTED : S_EXECUTE;
            S_EXECUTE:   st_nxt = S_WRITEBACK;
            S_WRITEBACK: st_nxt = step ? S_FETCH : S_IDLE;
            S_HALTED:    st_nxt = S_HALTED;
            default:     st_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        imem_rd_en   = 1'b0;
        result_valid = 1'b0;
        halted       = 1'b0;
        case (st)
            S_FETCH:     imem_rd_en   = 1'b1;
            S_WRITEBACK: result_valid = is_alu;
            S_HALTED:    halted       = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr = pc;
    assign state     = st;

    // ---------------- decode helpers ----------------
    assign is_rtype = (ir.op == OP_ADD) || (ir.op == OP_SUB) ||
                      (ir.op == OP_SHL) || (ir.op == OP_SHR);
    assign is_alu   = is_rtype || (ir.op == OP_ADDI) || (ir.op == OP_SUBI);
    assign wr_idx   = is_rtype ? ir.lo[15:11] : ir.rt;
    // Signed size cast sign-extends (or truncates when DATA_W < 16).
    assign imm_ext  = DATA_W'($signed(ir.lo));

    // Register-file read straight from the incoming instruction word so the
    // operands can be captured on the DECODE edge. The loop starts at 1, which
    // makes r0 and any index >= NREGS read as zero.
    always_comb begin
        rf_a = '0;
        rf_b = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (imem_data[25:21] == 5'(i)) rf_a = regs[i];
            if (imem_data[20:16] == 5'(i)) rf_b = regs[i];
        end
    end

    // ---------------- ALU and branch condition ----------------
    always_comb begin
        alu_y = '0;
        case (ir.op)
            OP_ADD:  alu_y = a + b;
            OP_SUB:  alu_y = a - b;
            OP_SHL:  alu_y = a << b[SH_W-1:0];
            OP_SHR:  alu_y = a >> b[SH_W-1:0];
            OP_ADDI: alu_y = a + imm_ext;
            OP_SUBI: alu_y = a - imm_ext;
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        br_take_nxt = 1'b0;
        case (ir.op)
            OP_BEQ:  br_take_nxt = (a == b);
`ifdef CPU_BNE_EN
            OP_BNE:  br_take_nxt = (a != b);
`endif
            OP_J:    br_take_nxt = 1'b1;
            default: br_take_nxt = 1'b0;
        endcase
    end

    // ---------------- datapath registers ----------------
    // Architectural state (pc, result, registers) only changes on the
    // WRITEBACK edge, so a reset anywhere earlier leaves no partial update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            aluout  <= '0;
            br_take <= 1'b0;
            pc      <= '0;
            result  <= '0;
            regs    <= '0;
        end else begin
            case (st)
                S_DECODE: begin
                    ir <= {imem_data[31:26], imem_data[20:16], imem_data[15:0]};
                    a  <= rf_a;
                    b  <= rf_b;
                end
                S_EXECUTE: begin
                    aluout  <= alu_y;
                    br_take <= br_take_nxt;
                end
                S_WRITEBACK: begin
                    // BEQ/BNE take imm[PC_W-1:0], J takes instr[PC_W-1:0];
                    // with PC_W <= 16 both are the low bits of `lo`.
                    pc <= br_take ? ir.lo[PC_W-1:0] : pc + PC_W'(1);
                    if (is_alu) begin
                        result <= aluout;
                        for (int i = 1; i < NREGS; i++) begin
                            if (wr_idx == 5'(i)) regs[i] <= aluout;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// tb_multicycle_cpu_core
//   Table of short programs (8 words each, rest of ROM filled with HALT),
//   each run to HALT and compared on final result and halt pc, followed by
//   hand-written sequences for cycle timing, HALT behaviour, single step,
//   mid-instruction reset and pc wrap. Configuration: DATA_W=16, PC_W=5,
//   NREGS=8.

module tb_multicycle_cpu_core;

    localparam int DATA_W = 16;
    localparam int PC_W   = 5;
    localparam int NREGS  = 8;

    localparam logic [5:0] ADD  = 6'b010000;
    localparam logic [5:0] SUB  = 6'b011000;
    localparam logic [5:0] SHL  = 6'b100000;
    localparam logic [5:0] SHR  = 6'b101000;
    localparam logic [5:0] ADDI = 6'b110000;
    localparam logic [5:0] SUBI = 6'b111000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [31:0] HLT = 32'hFC00_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] JMAX = 32'h0BFF_FFFF;   // J 0x3FFFFFF

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              step = 1'b0;
    logic              imem_rd_en;
    logic [PC_W-1:0]   imem_addr;
    logic [31:0]       imem_data = '0;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              halted;
    logic [2:0]        state;

    logic [31:0] rom [32];
    int n_cmp = 0;
    int n_bad = 0;

    multicycle_cpu_core #(.DATA_W(DATA_W), .PC_W(PC_W), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset), .step(step),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .pc(pc), .result(result), .result_valid(result_valid),
        .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: one-cycle read latency.
    always @(posedge clk) if (imem_rd_en) imem_data <= rom[imem_addr];

    typedef struct {
        string       name;
        logic [31:0] w [8];
        logic [15:0] exp_res;
        logic [4:0]  exp_pc;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [31:0] enc_r(logic [5:0] op, int rs, int rt, int rd);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'b0};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int k, input string nm,
                           input logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7,
                           input logic [15:0] er, input logic [4:0] ep);
        vecs[k].name = nm;
        vecs[k].w[0] = w0; vecs[k].w[1] = w1; vecs[k].w[2] = w2; vecs[k].w[3] = w3;
        vecs[k].w[4] = w4; vecs[k].w[5] = w5; vecs[k].w[6] = w6; vecs[k].w[7] = w7;
        vecs[k].exp_res = er;
        vecs[k].exp_pc  = ep;
    endtask

    task automatic fill_halt();
        for (int j = 0; j < 32; j++) rom[j] = HLT;
    endtask

    task automatic do_reset();
        @(negedge clk);
        step  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_until_halt(output logic [15:0] res, output logic [4:0] hpc, output bit done);
        done = 1'b0;
        res  = '0;
        hpc  = '0;
        do_reset();
        step = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (halted) begin
                res  = result;
                hpc  = pc;
                done = 1'b1;
                break;
            end
        end
        step = 1'b0;
    endtask

    initial begin
        logic [15:0] res;
        logic [4:0]  hpc;
        bit          done;
        int          k, cyc, errs;
        bit          pend;
        logic [15:0] s1_exp [3];
        logic [2:0]  prev;
        logic [4:0]  faddr [3];

        // ---------------- vector table ----------------
        set_vec(0, "add_chain", enc_i(ADDI,0,1,16'd5), enc_i(ADDI,0,2,16'd3), enc_r(ADD,1,2,3),
                enc_r(ADD,3,0,4), HLT, HLT, HLT, HLT, 16'h0008, 5'd4);
        set_vec(1, "subi_neg", enc_i(SUBI,0,1,16'd1), NOP, NOP, HLT, HLT, HLT, HLT, HLT,
                16'hFFFF, 5'd3);
        set_vec(2, "shr4", enc_i(SUBI,0,1,16'd1), enc_i(ADDI,0,4,16'd4), enc_r(SHR,1,4,2),
                HLT, HLT, HLT, HLT, HLT, 16'h0FFF, 5'd3);
        set_vec(3, "shl20", enc_i(SUBI,0,1,16'd1), enc_i(ADDI,0,4,16'd20), enc_r(SHL,1,4,2),
                HLT, HLT, HLT, HLT, HLT, 16'hFFF0, 5'd3);
        set_vec(4, "sub_wrap", enc_i(ADDI,0,1,16'd3), enc_i(ADDI,0,2,16'd5), enc_r(SUB,1,2,3),
                HLT, HLT, HLT, HLT, HLT, 16'hFFFE, 5'd3);
        set_vec(5, "addi_neg", enc_i(ADDI,0,1,16'hFFFF), enc_i(ADDI,1,2,16'hFFFE), HLT,
                HLT, HLT, HLT, HLT, HLT, 16'hFFFD, 5'd2);
        set_vec(6, "r0_write", enc_i(ADDI,0,0,16'd9), enc_r(ADD,0,0,1), HLT, HLT, HLT, HLT,
                HLT, HLT, 16'h0000, 5'd2);
        set_vec(7, "rhigh_write", enc_i(ADDI,0,12,16'd7), enc_r(ADD,12,0,1), HLT, HLT, HLT,
                HLT, HLT, HLT, 16'h0000, 5'd2);
        set_vec(8, "beq_taken", NOP, NOP, enc_i(BEQ,0,0,16'd7), enc_i(ADDI,0,5,16'd1), HLT,
                HLT, HLT, enc_i(ADDI,0,5,16'h77), 16'h0077, 5'd8);
        set_vec(9, "beq_not", enc_i(ADDI,0,1,16'd5), NOP, enc_i(BEQ,1,0,16'd7), HLT, HLT,
                HLT, HLT, enc_i(ADDI,0,2,16'h55), 16'h0005, 5'd3);
`ifdef CPU_BNE_EN
        set_vec(10, "bne_taken", enc_i(ADDI,0,1,16'd5), NOP, enc_i(BNE,1,0,16'd7), HLT, HLT,
                HLT, HLT, enc_i(ADDI,0,2,16'h55), 16'h0055, 5'd8);
`else
        set_vec(10, "bne_as_nop", enc_i(ADDI,0,1,16'd5), NOP, enc_i(BNE,1,0,16'd7), HLT, HLT,
                HLT, HLT, enc_i(ADDI,0,2,16'h55), 16'h0005, 5'd3);
`endif
        set_vec(11, "raw_chain", enc_i(ADDI,0,1,16'd5), enc_i(ADDI,1,1,16'd1), enc_r(ADD,1,1,2),
                HLT, HLT, HLT, HLT, HLT, 16'h000C, 5'd3);

        fill_halt();

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_imem_rd_en", 32'(imem_rd_en), 32'd0);

        // ---------------- S1: timing of ADDI/ADDI/ADD ----------------
        // cyc 0 is the first FETCH; pulses in the 4th, 8th, 12th cycles
        // counting FETCH as the first, i.e. cyc 3, 7, 11. result carries the
        // new value from the following cycle.
        fill_halt();
        rom[0] = enc_i(ADDI,0,1,16'd5);
        rom[1] = enc_i(ADDI,0,2,16'd3);
        rom[2] = enc_r(ADD,1,2,3);
        s1_exp[0] = 16'd5; s1_exp[1] = 16'd3; s1_exp[2] = 16'd8;
        step = 1'b1;
        k = 0;
        pend = 1'b0;
        for (cyc = 0; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                chk("s1_first_fetch_state", 32'(state), 32'd1);
                chk("s1_first_fetch_rd_en", 32'(imem_rd_en), 32'd1);
                chk("s1_first_fetch_addr", 32'(imem_addr), 32'd0);
            end
            if (pend) begin
                chk("s1_result", 32'(result), 32'(s1_exp[k-1]));
                pend = 1'b0;
            end
            if (result_valid) begin
                if (k < 3) begin
                    chk("s1_pulse_cycle", 32'(cyc), 32'(3 + 4*k));
                    pend = 1'b1;
                end
                k++;
            end
        end
        chk("s1_pulse_count", 32'(k), 32'd3);
        step = 1'b0;

        // ---------------- vector table loop ----------------
        for (int v = 0; v < 12; v++) begin
            fill_halt();
            for (int j = 0; j < 8; j++) rom[j] = vecs[v].w[j];
            run_until_halt(res, hpc, done);
            chk($sformatf("%s_halt_reached", vecs[v].name), 32'(done), 32'd1);
            chk($sformatf("%s_result", vecs[v].name), 32'(res), 32'(vecs[v].exp_res));
            chk($sformatf("%s_halt_pc", vecs[v].name), 32'(hpc), 32'(vecs[v].exp_pc));
        end

        // ---------------- S2: HALT at pc 4 ----------------
        fill_halt();
        for (int j = 0; j < 4; j++) rom[j] = NOP;
        do_reset();
        step = 1'b1;
        prev = 3'd0;
        done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (state == 3'd5) begin
                done = 1'b1;
                break;
            end
            prev = state;
        end
        chk("s2_halt_reached", 32'(done), 32'd1);
        chk("s2_prev_was_decode", 32'(prev), 32'd2);
        chk("s2_halted", 32'(halted), 32'd1);
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (pc !== 5'd4 || imem_rd_en !== 1'b0 || halted !== 1'b1 || state !== 3'd5) errs++;
        end
        chk("s2_hold_errors", 32'(errs), 32'd0);
        chk("s2_pc", 32'(pc), 32'd4);
        #2 reset = 1'b1;
        #1 chk("s2_reset_state", 32'(state), 32'd0);
        chk("s2_reset_halted", 32'(halted), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step  = 1'b0;

        // ---------------- S3: single-cycle step pulse ----------------
        fill_halt();
        rom[0] = enc_i(ADDI,0,1,16'd5);
        rom[1] = enc_i(ADDI,0,2,16'd6);
        do_reset();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        k = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (result_valid) k++;
        end
        chk("s3_pulse_count", 32'(k), 32'd1);
        chk("s3_state_idle", 32'(state), 32'd0);
        chk("s3_pc", 32'(pc), 32'd1);
        chk("s3_result", 32'(result), 32'd5);

        // ---------------- S4: reset during EXECUTE ----------------
        fill_halt();
        rom[0] = enc_i(ADDI,0,1,16'd5);
        do_reset();
        step = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (state == 3'd3) begin
                done = 1'b1;
                break;
            end
        end
        chk("s4_reached_execute", 32'(done), 32'd1);
        #2 reset = 1'b1;
        #1 chk("s4_async_state", 32'(state), 32'd0);
        chk("s4_async_pc", 32'(pc), 32'd0);
        // r1 must still be 0: r2 = r1 + 3 gives 3, not 8.
        rom[0] = enc_i(ADDI,1,2,16'd3);
        @(negedge clk);
        reset = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (halted) begin
                done = 1'b1;
                break;
            end
        end
        chk("s4_halt_reached", 32'(done), 32'd1);
        chk("s4_r1_clear", 32'(result), 32'd3);
        chk("s4_halt_pc", 32'(pc), 32'd1);

        // ---------------- S5: J to top of memory, NOP wraps pc ----------------
        fill_halt();
        rom[0]  = JMAX;
        rom[31] = NOP;
        do_reset();
        step = 1'b1;
        k = 0;
        for (int c = 0; c < 16 && k < 3; c++) begin
            @(negedge clk);
            if (imem_rd_en) begin
                faddr[k] = imem_addr;
                k++;
            end
        end
        step = 1'b0;
        chk("s5_fetch_count", 32'(k), 32'd3);
        if (k == 3) begin
            chk("s5_fetch0", 32'(faddr[0]), 32'd0);
            chk("s5_fetch_after_j", 32'(faddr[1]), 32'd31);
            chk("s5_fetch_after_wrap", 32'(faddr[2]), 32'd0);
        end
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
